// File: rtl/mmio_pkg.sv
// Shared constants and types for the MMIO debug port.
package mmio_pkg;

    localparam logic [31:0] MMIO_BASE_ADDR  = 32'hFFFF_0000;
    localparam logic [31:0] MMIO_DONE_OFF   = 32'h0000_0100;
    localparam logic [31:0] MMIO_STATUS_OFF = 32'h0000_0104;

    // Entry fields are sized for the largest supported configuration (16 channels, 32-bit data)
    localparam int MMIO_CH_W   = 4;
    localparam int MMIO_DATA_W = 32;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DONE    = 2'd1,
        TIMEOUT = 2'd2
    } mmio_state_e;

    typedef struct packed {
        logic [MMIO_CH_W-1:0]   channel;
        logic [MMIO_DATA_W-1:0] data;
    } mmio_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage and wrap-bit pointers; head is shown combinationally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/mmio_debug_port.sv
// MMIO print/DONE sink with tagged print FIFO, exit-code latch and cycle watchdog.
// Optional MMIO_READBACK_EN adds a registered STATUS register readable over the bus.
module mmio_debug_port
    import mmio_pkg::*;
#(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                NUM_CHANNELS   = 4,
    parameter int                FIFO_DEPTH     = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = ADDR_W'(MMIO_BASE_ADDR),
    parameter int                TIMEOUT_CYCLES = 100000,
    localparam int               CH_W           = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int               LVL_W          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [ADDR_W-1:0] memory_address,
    input  logic [DATA_W-1:0] memory_write_data,
    input  logic              memory_write_enable,
    input  logic              memory_read_enable,
    output logic [DATA_W-1:0] memory_read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_channel,
    output logic [DATA_W-1:0] out_data,
    output logic              done,
    output logic [DATA_W-1:0] exit_code,
    output logic              timeout,
    output logic              overflow,
    output logic [15:0]       drop_count
);

    mmio_state_e       state_q, state_d;
    logic [31:0]       wd_count;
    logic              wd_expire;
    logic [ADDR_W-1:0] offset;
    logic              ch_hit, done_wr;
    logic [CH_W-1:0]   ch_idx;
    mmio_entry_t       push_entry, head_entry;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty, drop;
    logic [LVL_W-1:0]  fifo_level;

    // Addresses below BASE_ADDR wrap to a huge offset and fall outside the channel window
    assign offset  = memory_address - BASE_ADDR;
    assign ch_hit  = (offset < ADDR_W'(4 * NUM_CHANNELS)) && (memory_address[1:0] == 2'b00);
    assign ch_idx  = CH_W'(offset >> 2);
    assign done_wr = memory_write_enable && (memory_address == BASE_ADDR + ADDR_W'(MMIO_DONE_OFF));

    assign wd_expire = (TIMEOUT_CYCLES != 0) && (wd_count == 32'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (done_wr)        state_d = DONE;
                else if (wd_expire) state_d = TIMEOUT;
            end
            default: state_d = state_q;
        endcase
    end

    assign done    = (state_q == DONE);
    assign timeout = (state_q == TIMEOUT);

    assign push_entry.channel = MMIO_CH_W'(ch_idx);
    assign push_entry.data    = MMIO_DATA_W'(memory_write_data);
    assign fifo_push          = memory_write_enable && ch_hit && (state_q == RUN);
    assign fifo_pop           = out_valid && out_ready;
    assign drop               = fifo_push && fifo_full && !fifo_pop;

    sync_fifo #(
        .WIDTH ($bits(mmio_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (push_entry),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Head fields are masked so an empty FIFO (including right after reset) shows zeros
    assign out_valid   = !fifo_empty;
    assign out_channel = out_valid ? CH_W'(head_entry.channel) : '0;
    assign out_data    = out_valid ? DATA_W'(head_entry.data) : '0;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q    <= RUN;
            wd_count   <= '0;
            exit_code  <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == RUN) wd_count <= wd_count + 32'd1;
            if (state_q == RUN && done_wr) exit_code <= memory_write_data;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end
        end
    end

`ifdef MMIO_READBACK_EN
    logic [31:0] status_word;

    assign status_word = {drop_count, 8'(fifo_level), 4'b0000, timeout, done, overflow, fifo_full};

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            memory_read_data <= '0;
        end else if (memory_read_enable) begin
            if (memory_address == BASE_ADDR + ADDR_W'(MMIO_STATUS_OFF))
                memory_read_data <= DATA_W'(status_word);
            else
                memory_read_data <= '0;
        end
    end
`else
    logic unused_readback;

    assign unused_readback  = ^{memory_read_enable, fifo_level};
    assign memory_read_data = '0;
`endif

endmodule
